// File: rtl/depacketizer_pkg.sv
// Shared definitions for the voltage-packet receive path: FSM states and
// the word/lane layout agreed with the packetizer.
package depacketizer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POL_A = 2'd1,
        POL_B = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam int WORD_W           = 64;
    localparam int SAMPLE_W         = 16;
    localparam int SAMPLES_PER_WORD = WORD_W / SAMPLE_W;

    // Sample 0 sits in the MSBs on both sides of the link, so words pass through unswizzled.
    localparam bit LANE_SAMPLE0_MSB = 1'b1;

    // Position of the payload_id word within a packet.
    localparam int HEADER_IDX = 0;

endpackage

// File: rtl/depacketizer_pair_buffer.sv
// Simple dual-port pol-A staging RAM: one write port, one read port with a
// registered read. The data array is left unreset so it maps onto block RAM.
module pair_buffer #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/depacketizer.sv
// Rebuilds time-aligned pol-A/pol-B word pairs from the header/A-block/B-block
// packet stream, checking packet length and payload_id continuity.
module depacketizer
    import depacketizer_pkg::*;
#(
    parameter int N_WORDS = 512,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_eod,
    output logic [WORD_W-1:0] out_a,
    output logic [WORD_W-1:0] out_b,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_abort,
    output logic [WORD_W-1:0] out_id,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic [CNT_W-1:0]  seq_err_count
);

    localparam int                ADDR_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);
    localparam int                N_CNT    = 3;   // [0] good packets, [1] drops, [2] sequence errors

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   widx_reg, widx_next;
    logic [WORD_W-1:0]   expected_reg;
    logic                exp_valid_reg;

    logic                wr_en, rd_en, hdr_accept, len_err;
    logic                pair_next, sop_next, eop_next, abort_next;
    logic [N_CNT-1:0]    cnt_inc;
    logic [WORD_W-1:0]   rd_data;

    logic                s1_valid_reg, s1_sop_reg, s1_eop_reg, s1_abort_reg;
    logic [WORD_W-1:0]   s1_b_reg;

    pair_buffer #(
        .DEPTH  (N_WORDS),
        .WIDTH  (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_pair_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (widx_reg),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .rd_addr (widx_reg),
        .rd_data (rd_data)
    );

    always_comb begin
        state_next = state_reg;
        widx_next  = widx_reg;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        hdr_accept = 1'b0;
        len_err    = 1'b0;
        pair_next  = 1'b0;
        sop_next   = 1'b0;
        eop_next   = 1'b0;
        abort_next = 1'b0;
        cnt_inc    = '0;

        if (rx_valid) begin
            case (state_reg)
                IDLE: begin
                    hdr_accept = 1'b1;
                    cnt_inc[2] = exp_valid_reg && (rx_data != expected_reg);
                    if (rx_eod) begin
                        cnt_inc[1] = 1'b1;
                        len_err    = 1'b1;
                    end else begin
                        state_next = POL_A;
                        widx_next  = '0;
                    end
                end
                POL_A: begin
                    if (rx_eod) begin
                        cnt_inc[1] = 1'b1;
                        len_err    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        wr_en     = 1'b1;
                        widx_next = widx_reg + 1'b1;
                        if (widx_reg == LAST_IDX) begin
                            state_next = POL_B;
                            widx_next  = '0;
                        end
                    end
                end
                POL_B: begin
                    widx_next = widx_reg + 1'b1;
                    if (widx_reg == LAST_IDX) begin
                        // Final B word always yields its pair; a missing eod only adds the abort.
                        rd_en     = 1'b1;
                        pair_next = 1'b1;
                        sop_next  = (widx_reg == '0);
                        if (rx_eod) begin
                            eop_next   = 1'b1;
                            cnt_inc[0] = 1'b1;
                            state_next = IDLE;
                        end else begin
                            abort_next = 1'b1;
                            cnt_inc[1] = 1'b1;
                            len_err    = 1'b1;
                            state_next = DROP;
                        end
                    end else if (rx_eod) begin
                        abort_next = 1'b1;
                        cnt_inc[1] = 1'b1;
                        len_err    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        rd_en     = 1'b1;
                        pair_next = 1'b1;
                        sop_next  = (widx_reg == '0);
                    end
                end
                DROP: begin
                    if (rx_eod) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            widx_reg      <= '0;
            expected_reg  <= '0;
            exp_valid_reg <= 1'b0;
            out_id        <= '0;
        end else begin
            state_reg <= state_next;
            widx_reg  <= widx_next;
            if (hdr_accept) begin
                out_id       <= rx_data;
                expected_reg <= rx_data + 64'd1;
            end
            // A length error restarts continuity tracking from the next header.
            if (len_err) begin
                exp_valid_reg <= 1'b0;
            end else if (hdr_accept) begin
                exp_valid_reg <= 1'b1;
            end
        end
    end

    // Stage 1 lines up with the RAM read; stage 2 is the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_sop_reg   <= 1'b0;
            s1_eop_reg   <= 1'b0;
            s1_abort_reg <= 1'b0;
            s1_b_reg     <= '0;
            out_valid    <= 1'b0;
            out_sop      <= 1'b0;
            out_eop      <= 1'b0;
            out_abort    <= 1'b0;
            out_a        <= '0;
            out_b        <= '0;
        end else begin
            s1_valid_reg <= pair_next;
            s1_sop_reg   <= sop_next;
            s1_eop_reg   <= eop_next;
            s1_abort_reg <= abort_next;
            if (pair_next) begin
                s1_b_reg <= rx_data;
            end
            out_valid <= s1_valid_reg;
            out_sop   <= s1_sop_reg;
            out_eop   <= s1_eop_reg;
            out_abort <= s1_abort_reg;
            if (s1_valid_reg) begin
                out_a <= rd_data;
                out_b <= s1_b_reg;
            end
        end
    end

    logic [CNT_W-1:0] cnt_val [N_CNT];

    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (cnt_inc[gi] && !(&cnt_reg)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        assign cnt_val[gi] = cnt_reg;
    end

    assign pkt_count     = cnt_val[0];
    assign drop_count    = cnt_val[1];
    assign seq_err_count = cnt_val[2];

endmodule
